cla_signed_add_sub_unit: RTL and testbench

Parameterised two's-complement adder/subtractor built on a carry-lookahead (CLA) tree. The sum or difference, carry-out and signed overflow are combinational. An optional registered copy of the results is also provided. The block is a leaf arithmetic unit for datapaths that need one-cycle-or-less signed add/sub without ripple-carry delay.

---
 rtl/cla_signed_add_sub_unit.sv | 123 ++++++++++++
 tb/tb_cla_signed_add_sub_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cla_signed_add_sub_unit.sv
// +--------------------------------------------------------------------------+
// | cla_signed_add_sub_unit: signed add/sub on a two-level carry-lookahead   |
// | tree. Optional output register via CLA_SIGNED_ADD_SUB_OUT_REG_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cla_signed_add_sub_unit #(
  parameter int DATA_IN_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sub_nadd,
  input  logic [DATA_IN_W-1:0] inp_A_i,
  input  logic [DATA_IN_W-1:0] inp_B_i,
  output logic [DATA_IN_W-1:0] out_o,
  output logic                 carry_o,
  output logic                 ovf_o,
  output logic [DATA_IN_W-1:0] out_q_o,
  output logic                 carry_q_o,
  output logic                 ovf_q_o
);

  localparam int NG = DATA_IN_W / 4;

  logic [DATA_IN_W-1:0] w_beff;
  logic [DATA_IN_W-1:0] w_g;
  logic [DATA_IN_W-1:0] w_p;
  logic [DATA_IN_W:0]   w_c;
  logic [NG-1:0]        w_gg;
  logic [NG-1:0]        w_gp;
  logic [NG:0]          w_bc;

  assign w_beff = inp_B_i ^ {DATA_IN_W{sub_nadd}};
  assign w_g    = inp_A_i & w_beff;
  assign w_p    = inp_A_i ^ w_beff;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic [3:0] w_gl;
      logic [3:0] w_pl;
      logic       w_ci;

      assign w_gl = w_g[4*gi +: 4];
      assign w_pl = w_p[4*gi +: 4];
      assign w_ci = w_bc[gi];

      assign w_c[4*gi]     = w_ci;
      assign w_c[4*gi + 1] = w_gl[0] | (w_pl[0] & w_ci);
      assign w_c[4*gi + 2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_ci);
      assign w_c[4*gi + 3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                           | (w_pl[2] & w_pl[1] & w_pl[0] & w_ci);

      assign w_gg[gi] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                      | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
      assign w_gp[gi] = &w_pl;
    end
  endgenerate

  // Each block carry is a flat sum-of-products over (G, P) pairs, never chained.
  always_comb begin
    logic w_term;
    logic w_acc;
    w_bc    = '0;
    w_bc[0] = sub_nadd;
    for (int k = 1; k <= NG; k++) begin
      w_term = sub_nadd;
      for (int j = 0; j < k; j++) w_term = w_term & w_gp[j];
      w_acc = w_term;
      for (int j = 0; j < k; j++) begin
        w_term = w_gg[j];
        for (int m = j + 1; m < k; m++) w_term = w_term & w_gp[m];
        w_acc = w_acc | w_term;
      end
      w_bc[k] = w_acc;
    end
  end

  assign w_c[DATA_IN_W] = w_bc[NG];

  assign out_o   = w_p ^ w_c[DATA_IN_W-1:0];
  assign carry_o = w_c[DATA_IN_W];
  assign ovf_o   = w_c[DATA_IN_W] ^ w_c[DATA_IN_W-1];

`ifdef CLA_SIGNED_ADD_SUB_OUT_REG_EN
  logic [DATA_IN_W-1:0] out_reg_d, out_reg_q;
  logic                 carry_reg_d, carry_reg_q;
  logic                 ovf_reg_d, ovf_reg_q;

  always_comb begin
    out_reg_d   = out_o;
    carry_reg_d = carry_o;
    ovf_reg_d   = ovf_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_reg_q   <= '0;
      carry_reg_q <= 1'b0;
      ovf_reg_q   <= 1'b0;
    end else begin
      out_reg_q   <= out_reg_d;
      carry_reg_q <= carry_reg_d;
      ovf_reg_q   <= ovf_reg_d;
    end
  end

  assign out_q_o   = out_reg_q;
  assign carry_q_o = carry_reg_q;
  assign ovf_q_o   = ovf_reg_q;
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = &{1'b0, clk_i, rst_n_i};

  assign out_q_o   = '0;
  assign carry_q_o = 1'b0;
  assign ovf_q_o   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_signed_add_sub_unit.sv
// +--------------------------------------------------------------------------+
// | tb_cla_signed_add_sub_unit: directed, swept and random checks of the     |
// | signed CLA add/sub against a plain-integer model. Revision: 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cla_signed_add_sub_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sub_nadd = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] out_o, out_q_o;
  logic         carry_o, ovf_o, carry_q_o, ovf_q_o;

  int n_assert = 0;
  int n_fail   = 0;

  cla_signed_add_sub_unit #(.DATA_IN_W(W)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .sub_nadd (sub_nadd),
    .inp_A_i  (a),
    .inp_B_i  (b),
    .out_o    (out_o),
    .carry_o  (carry_o),
    .ovf_o    (ovf_o),
    .out_q_o  (out_q_o),
    .carry_q_o(carry_q_o),
    .ovf_q_o  (ovf_q_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Integer-level reference: true signed result, wrapped output, range-based overflow.
  task automatic model(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output logic [W-1:0] eo, output logic ec, output logic ev);
    longint sa, sb, res, ua, ub;
    sa  = longint'($signed(ia));
    sb  = longint'($signed(ib));
    ua  = longint'(ia);
    ub  = longint'(ib);
    res = s ? (sa - sb) : (sa + sb);
    eo  = res[W-1:0];
    ev  = (res > ((64'sd1 <<< (W-1)) - 1)) || (res < -(64'sd1 <<< (W-1)));
    ec  = s ? (ua >= ub) : ((ua + ub) >= (64'sd1 <<< W));
  endtask

  task automatic drive(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib);
    sub_nadd = s;
    a        = ia;
    b        = ib;
    #1;
  endtask

  task automatic directed(input string tag, input logic s, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input logic [W-1:0] eo,
                          input logic ec, input logic ev);
    drive(s, ia, ib);
    chk({tag, ".out"},   out_o,   eo);
    chk({tag, ".carry"}, {15'd0, carry_o}, {15'd0, ec});
    chk({tag, ".ovf"},   {15'd0, ovf_o},   {15'd0, ev});
  endtask

  task automatic vs_model(input string tag, input logic s, input logic [W-1:0] ia,
                          input logic [W-1:0] ib);
    logic [W-1:0] eo;
    logic ec, ev;
    model(s, ia, ib, eo, ec, ev);
    directed(tag, s, ia, ib, eo, ec, ev);
  endtask

  initial begin
    logic [W-1:0] exp_q;
    logic [W-1:0] ra, rb;
    int           sum_ij;

    // Test-plan vectors with hand-derived expectations
    directed("add_5_3",        1'b0, 16'd5,    16'd3,    16'd8,    1'b0, 1'b0);
    directed("sub_5_3",        1'b1, 16'd5,    16'd3,    16'd2,    1'b1, 1'b0);
    directed("add_m128_m128",  1'b0, 16'hFF80, 16'hFF80, 16'hFF00, 1'b1, 1'b0);
    directed("sub_m128_126",   1'b1, 16'hFF80, 16'd126,  16'hFF02, 1'b1, 1'b0);
    directed("ovf_add_max",    1'b0, 16'h7FFF, 16'd1,    16'h8000, 1'b0, 1'b1);
    directed("ovf_sub_min",    1'b1, 16'h8000, 16'd1,    16'h7FFF, 1'b1, 1'b1);
    directed("sub_0_0",        1'b1, 16'd0,    16'd0,    16'd0,    1'b1, 1'b0);
    directed("sub_0_1",        1'b1, 16'd0,    16'd1,    16'hFFFF, 1'b0, 1'b0);
    directed("add_m1_m1",      1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
    directed("ovf_add_min",    1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);

    // Sweep small signed operands; result must equal exact integer sum/difference
    for (int s = 0; s < 2; s++) begin
      for (int i = -128; i <= 126; i++) begin
        for (int j = -128; j <= 126; j++) begin
          drive(s[0], W'(i), W'(j));
          sum_ij = (s == 1) ? (i - j) : (i + j);
          n_assert++;
          assert (int'($signed(out_o)) == sum_ij) else begin
            n_fail++;
            $error("FAIL sweep s=%0d a=%0d b=%0d observed=%0d expected=%0d",
                   s, i, j, int'($signed(out_o)), sum_ij);
          end
        end
      end
    end

    // Random full-range operands, including sign-boundary biased picks
    for (int n = 0; n < 400; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 4 == 1) ra[W-2:0] = {(W-1){ra[0]}};
      if (n % 4 == 2) rb[W-2:0] = {(W-1){rb[0]}};
      vs_model("rand", 1'($urandom), ra, rb);
    end

    // Registered stage
    drive(1'b0, 16'd5, 16'd3);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.out_q",   out_q_o, '0);
    chk("rst.carry_q", {15'd0, carry_q_o}, '0);
    chk("rst.ovf_q",   {15'd0, ovf_q_o},   '0);

    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef CLA_SIGNED_ADD_SUB_OUT_REG_EN
    exp_q = 16'd8;
`else
    exp_q = 16'd0;
`endif
    chk("reg_add.out_q", out_q_o, exp_q);

    sub_nadd = 1'b1; #1;
    chk("reg_sub.out_comb", out_o, 16'd2);
    chk("reg_sub.out_q_hold", out_q_o, exp_q);
    @(posedge clk); #1;
`ifdef CLA_SIGNED_ADD_SUB_OUT_REG_EN
    exp_q = 16'd2;
    chk("reg_sub.carry_q", {15'd0, carry_q_o}, 16'd1);
`else
    exp_q = 16'd0;
    chk("reg_sub.carry_q", {15'd0, carry_q_o}, 16'd0);
`endif
    chk("reg_sub.out_q", out_q_o, exp_q);

    drive(1'b0, 16'h7FFF, 16'd1);
    @(posedge clk); #1;
`ifdef CLA_SIGNED_ADD_SUB_OUT_REG_EN
    chk("reg_ovf.ovf_q", {15'd0, ovf_q_o}, 16'd1);
    chk("reg_ovf.out_q", out_q_o, 16'h8000);
`else
    chk("reg_ovf.ovf_q", {15'd0, ovf_q_o}, 16'd0);
    chk("reg_ovf.out_q", out_q_o, 16'h0000);
`endif

    drive(1'b1, 16'd5, 16'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst.out_q", out_q_o, '0);
    chk("mid_rst.ovf_q", {15'd0, ovf_q_o}, '0);
    chk("mid_rst.out_comb", out_o, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
